rgmii_tx_sequencer: RTL and testbench
=====================================

RGMII_TX_SEQUENCER -- requirements
Module: rgmii_tx_sequencer

Interface
REQ-001 SHALL have parameter IFG_BYTES, default 12, minimum idle byte-times between frames (range 1..255).
REQ-002 SHALL have parameter DIV_100, default 5, clk cycles per TX clock period at 100M (range 2..255).
REQ-003 SHALL have parameter DIV_10, default 50, clk cycles per TX clock period at 10M (range 2..255).
REQ-004 SHALL have one clock and one reset: clk, input, 1, rising-edge system clock (125 MHz nominal); rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port speed, input, 2: 2'b00 = 10M, 2'b01 = 100M, 2'b10/2'b11 = 1G.
REQ-006 SHALL have byte stream inputs s_axis_tdata (8), s_axis_tvalid (1), s_axis_tlast (1), s_axis_tuser (1, per-byte TX error request), and output s_axis_tready (1).
REQ-007 SHALL have outputs txd_d1 (4), txd_d2 (4), txctl_d1 (1), txctl_d2 (1), txc_d1 (1), txc_d2 (1) driving rising/falling-half inputs of external DDR output registers.
REQ-008 SHALL have outputs busy (1, high when not IDLE) and status_underrun (1, one-cycle pulse).

Function
REQ-009 All outputs except s_axis_tready SHALL be registered; s_axis_tready SHALL be a registered strobe or level as defined below.
REQ-010 States SHALL be IDLE, DATA, DRAIN, IFG; a byte is transferred when tvalid and tready are both high.
REQ-011 speed SHALL be sampled only in IDLE; changes during DATA/DRAIN/IFG take effect on the next return to IDLE.
REQ-012 1G: txc_d1=1, txc_d2=0 every cycle (including idle); tready SHALL be high in IDLE and DATA, low in DRAIN-excepted cases and in IFG.
REQ-013 1G: byte accepted in cycle N SHALL appear in cycle N+1 as txd_d1=tdata[3:0], txd_d2=tdata[7:4], txctl_d1=1, txctl_d2=1^tuser.
REQ-014 10/100: phase counter p SHALL run 0..DIV-1 (DIV=DIV_10 or DIV_100) continuously while not in reset; txc_d1=(2p<DIV), txc_d2=(2p+1<DIV).
REQ-015 10/100: data/ctl outputs SHALL change only in the cycle with p=ceil(DIV/2); txd_d1=txd_d2 = current nibble, txctl_d1=1, txctl_d2=1^tuser.
REQ-016 10/100: each byte SHALL occupy two TX clock periods, low nibble first, then high nibble.
REQ-017 10/100: tready SHALL be a one-cycle strobe in the cycle with p=ceil(DIV/2)-1 of the high-nibble period (or any period when idle), only in IDLE/DATA/DRAIN.
REQ-018 IDLE -> DATA on accepted byte; DATA stays while bytes arrive each slot; accepted byte with tlast -> IFG after that byte is fully output.
REQ-019 Underrun: in DATA, a byte slot with tvalid low SHALL output one byte-time of txd=0, txctl_d1=1, txctl_d2=0, pulse status_underrun, enter DRAIN.
REQ-020 DRAIN: tready high (1G) or strobed (10/100); accepted bytes discarded, outputs idle (txd=0, txctl=0); accepted tlast -> IFG.
REQ-021 IFG: outputs idle, tready low, count IFG_BYTES byte-times (1 clk at 1G; 2*DIV clk at 10/100), then IDLE.
REQ-022 Idle outputs (IDLE, DRAIN, IFG) SHALL be txd_d1=txd_d2=0, txctl_d1=txctl_d2=0; txc continues per speed.
REQ-023 Single-byte frame (tlast on first byte) SHALL be legal: one byte output, then IFG.

Reset
REQ-024 While rst high: state IDLE, p=0, IFG counter 0, all outputs 0 (including txc_d1/txc_d2, tready, busy, status_underrun).
REQ-025 Reset asserted mid-frame SHALL abort immediately; no tail bytes or error symbol after deassertion; first cycle after release behaves as IDLE.

Verification
REQ-026 1G, 4-byte frame 0x11,0x22,0x33,0x44 back-to-back with tlast on 0x44 -> txd_d1/d2 = 1/1,2/2,3/3,4/4 on cycles N+1..N+4, txctl=1/1; tready low for 12 cycles after tlast accept.
REQ-027 100M (DIV_100=5) -> txc_d1/txc_d2 pattern per 5 cycles 11,11,10,00,00; byte 0xA5 gives txd=5 for 5 cycles then A for 5 cycles, changes at p=3.
REQ-028 1G underrun: tvalid drops after byte 2 of frame -> next cycle txd=0, txctl_d1=1, txctl_d2=0, status_underrun pulse; following bytes discarded until tlast; IFG then IDLE.
REQ-029 1G tuser=1 on byte 0x3C -> txd_d1=0xC, txd_d2=0x3, txctl_d1=1, txctl_d2=0.
REQ-030 speed changed 1G->10M in mid-frame -> frame completes at 1G; after IFG, txc high 25 cycles/low 25 cycles.
REQ-031 rst pulsed during byte 3 of 10M frame -> all outputs 0 during reset; after release no txctl activity until a new tvalid.

Source files
------------

// File: rtl/rgmii_tx_sequencer.sv
// Byte-stream to RGMII DDR-register sequencer with 10/100/1000 pacing, underrun
// handling and inter-frame gap. The valid/ready handshake is described on the ports.
module rgmii_tx_sequencer #(
   parameter int IFG_BYTES = 12,
   parameter int DIV_100   = 5,
   parameter int DIV_10    = 50
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] speed,
   // A byte moves on a rising clk edge where s_axis_tvalid and s_axis_tready are
   // both high; tready never depends combinationally on tvalid.
   input  logic [7:0] s_axis_tdata,
   input  logic       s_axis_tvalid,
   input  logic       s_axis_tlast,
   input  logic       s_axis_tuser,
   output logic       s_axis_tready,
   output logic [3:0] txd_d1,
   output logic [3:0] txd_d2,
   output logic       txctl_d1,
   output logic       txctl_d2,
   output logic       txc_d1,
   output logic       txc_d2,
   output logic       busy,
   output logic       status_underrun
);

   typedef enum logic [1:0] {IDLE, DATA, DRAIN, IFG} state_t;

   localparam logic [7:0]  DIV10_W  = 8'(DIV_10);
   localparam logic [7:0]  DIV100_W = 8'(DIV_100);
   localparam logic [7:0]  HM1_10   = 8'((DIV_10 + 1) / 2 - 1);
   localparam logic [7:0]  HM1_100  = 8'((DIV_100 + 1) / 2 - 1);
   localparam logic [16:0] IFG_1G   = 17'(IFG_BYTES);
   localparam logic [16:0] IFG_10   = 17'(IFG_BYTES * 2 * DIV_10);
   localparam logic [16:0] IFG_100  = 17'(IFG_BYTES * 2 * DIV_100);

   function automatic logic [7:0] div_sel(input logic [1:0] s);
      return (s == 2'b00) ? DIV10_W : DIV100_W;
   endfunction

   function automatic logic [7:0] hm1_sel(input logic [1:0] s);
      return (s == 2'b00) ? HM1_10 : HM1_100;
   endfunction

   state_t      state_q, state_d;
   logic [1:0]  spd_q, spd_d;
   logic [7:0]  p_q, p_d;
   logic        hi_q, hi_d;
   logic        last_q, last_d;
   logic [7:0]  byte_q, byte_d;
   logic        user_q, user_d;
   logic [16:0] ifg_cnt_q, ifg_cnt_d;
   logic [3:0]  txd1_q, txd1_d, txd2_q, txd2_d;
   logic        ctl1_q, ctl1_d, ctl2_q, ctl2_d;
   logic        txc1_q, txc1_d, txc2_q, txc2_d;
   logic        tready_q, tready_d;
   logic        busy_q, busy_d;
   logic        underrun_q, underrun_d;

   logic        mode_1g, upd, acc, start_byte, enter_ifg;
   logic [7:0]  div_nxt;
   logic [16:0] ifg_load;

   always_comb begin
      state_d    = state_q;
      spd_d      = spd_q;
      p_d        = p_q;
      hi_d       = hi_q;
      last_d     = last_q;
      byte_d     = byte_q;
      user_d     = user_q;
      ifg_cnt_d  = ifg_cnt_q;
      txd1_d     = txd1_q;
      txd2_d     = txd2_q;
      ctl1_d     = ctl1_q;
      ctl2_d     = ctl2_q;
      underrun_d = 1'b0;
      start_byte = 1'b0;
      enter_ifg  = 1'b0;
      mode_1g    = spd_q[1];
      // upd marks the last cycle before the line may change; hi_q means the high
      // nibble (or second half of an error byte) still has to be shown.
      upd        = mode_1g | (p_q == hm1_sel(spd_q));
      acc        = s_axis_tvalid & tready_q;
      ifg_load   = mode_1g ? IFG_1G : ((spd_q == 2'b00) ? IFG_10 : IFG_100);

      case (state_q)
         IDLE: begin
            if (upd) begin
               {txd1_d, txd2_d, ctl1_d, ctl2_d} = '0;
               start_byte = acc;
            end
         end
         DATA: begin
            if (upd) begin
               if (hi_q) begin
                  txd1_d    = byte_q[7:4];
                  txd2_d    = byte_q[7:4];
                  ctl1_d    = 1'b1;
                  ctl2_d    = ~user_q;
                  hi_d      = 1'b0;
                  enter_ifg = last_q;
               end else if (acc) begin
                  start_byte = 1'b1;
               end else begin
                  txd1_d     = 4'h0;
                  txd2_d     = 4'h0;
                  ctl1_d     = 1'b1;
                  ctl2_d     = 1'b0;
                  underrun_d = 1'b1;
                  hi_d       = ~mode_1g;
                  state_d    = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (upd) begin
               if (hi_q) begin
                  hi_d = 1'b0;
               end else begin
                  {txd1_d, txd2_d, ctl1_d, ctl2_d} = '0;
                  hi_d      = acc & ~mode_1g;
                  enter_ifg = acc & s_axis_tlast;
               end
            end
         end
         default: begin
            if (upd) begin
               {txd1_d, txd2_d, ctl1_d, ctl2_d} = '0;
            end
            if (ifg_cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               ifg_cnt_d = ifg_cnt_q - 17'd1;
            end
         end
      endcase

      if (start_byte) begin
         byte_d  = s_axis_tdata;
         user_d  = s_axis_tuser;
         last_d  = s_axis_tlast;
         ctl1_d  = 1'b1;
         ctl2_d  = ~s_axis_tuser;
         txd1_d  = s_axis_tdata[3:0];
         state_d = DATA;
         if (mode_1g) begin
            txd2_d    = s_axis_tdata[7:4];
            enter_ifg = s_axis_tlast;
         end else begin
            txd2_d = s_axis_tdata[3:0];
            hi_d   = 1'b1;
         end
      end

      // The gap is counted from the cycle the frame's final symbol appears.
      if (enter_ifg) begin
         state_d   = IFG;
         ifg_cnt_d = ifg_load - 17'd1;
         hi_d      = 1'b0;
      end

      if ((state_q == IDLE) && (state_d == IDLE)) begin
         spd_d = speed;
      end

      div_nxt = div_sel(spd_d);
      if (spd_d[1] || (p_q >= div_nxt - 8'd1)) begin
         p_d = 8'd0;
      end else begin
         p_d = p_q + 8'd1;
      end

      txc1_d   = spd_d[1] | ({1'b0, p_d, 1'b0} < {2'b00, div_nxt});
      txc2_d   = ~spd_d[1] & ({1'b0, p_d, 1'b1} < {2'b00, div_nxt});
      tready_d = (state_d != IFG) & (spd_d[1] | ((p_d == hm1_sel(spd_d)) & ~hi_d));
      busy_d   = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         spd_q      <= 2'b00;
         p_q        <= 8'd0;
         hi_q       <= 1'b0;
         last_q     <= 1'b0;
         byte_q     <= 8'd0;
         user_q     <= 1'b0;
         ifg_cnt_q  <= 17'd0;
         txd1_q     <= 4'h0;
         txd2_q     <= 4'h0;
         ctl1_q     <= 1'b0;
         ctl2_q     <= 1'b0;
         txc1_q     <= 1'b0;
         txc2_q     <= 1'b0;
         tready_q   <= 1'b0;
         busy_q     <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         spd_q      <= spd_d;
         p_q        <= p_d;
         hi_q       <= hi_d;
         last_q     <= last_d;
         byte_q     <= byte_d;
         user_q     <= user_d;
         ifg_cnt_q  <= ifg_cnt_d;
         txd1_q     <= txd1_d;
         txd2_q     <= txd2_d;
         ctl1_q     <= ctl1_d;
         ctl2_q     <= ctl2_d;
         txc1_q     <= txc1_d;
         txc2_q     <= txc2_d;
         tready_q   <= tready_d;
         busy_q     <= busy_d;
         underrun_q <= underrun_d;
      end
   end

   assign s_axis_tready   = tready_q;
   assign txd_d1          = txd1_q;
   assign txd_d2          = txd2_q;
   assign txctl_d1        = ctl1_q;
   assign txctl_d2        = ctl2_q;
   assign txc_d1          = txc1_q;
   assign txc_d2          = txc2_q;
   assign busy            = busy_q;
   assign status_underrun = underrun_q;

endmodule

// File: tb/tb_rgmii_tx_sequencer.sv
// Bench for rgmii_tx_sequencer: a queue-based line model checked every cycle,
// plus directed frames with literal expectations at 1G, 100M and 10M.
module tb_rgmii_tx_sequencer;

   localparam int IFG_BYTES = 12;
   localparam int DIV_100   = 5;
   localparam int DIV_10    = 50;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [1:0] speed;
   logic [7:0] s_axis_tdata;
   logic       s_axis_tvalid;
   logic       s_axis_tlast;
   logic       s_axis_tuser;
   logic       s_axis_tready;
   logic [3:0] txd_d1, txd_d2;
   logic       txctl_d1, txctl_d2, txc_d1, txc_d2, busy, status_underrun;

   int n_checks = 0;
   int n_fail   = 0;

   rgmii_tx_sequencer #(.IFG_BYTES(IFG_BYTES), .DIV_100(DIV_100), .DIV_10(DIV_10)) dut (
      .clk(clk), .rst(rst), .speed(speed),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
      .s_axis_tready(s_axis_tready),
      .txd_d1(txd_d1), .txd_d2(txd_d2), .txctl_d1(txctl_d1), .txctl_d2(txctl_d2),
      .txc_d1(txc_d1), .txc_d2(txc_d2), .busy(busy), .status_underrun(status_underrun)
   );

   // clock / reset
   always #4 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- model ----------------
   // The line is a queue of symbols waiting to be shown; each update opportunity
   // shows the next one (or idle). A new byte is only taken when the queue is empty.
   int          m_state;   // 0 idle, 1 data, 2 drain, 3 gap
   int          m_nst, m_p, m_ifg, m_div;
   logic [1:0]  m_spd;
   logic        m_gig, m_upd, m_acc;
   logic [10:0] m_ent;
   logic [10:0] exp_q[$];  // {last, txd_d1, txd_d2, txctl_d1, txctl_d2}
   logic [3:0]  e_txd1 = '0, e_txd2 = '0;
   logic        e_c1 = 0, e_c2 = 0, e_txc1 = 0, e_txc2 = 0, e_tready = 0, e_busy = 0, e_under = 0;

   function automatic int div_of(input logic [1:0] s);
      return (s == 2'b00) ? DIV_10 : DIV_100;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_state = 0; m_p = 0; m_ifg = 0; m_spd = 2'b00;
         exp_q.delete();
         {e_txd1, e_txd2, e_c1, e_c2, e_txc1, e_txc2, e_tready, e_busy, e_under} = '0;
      end else begin
         m_gig   = m_spd[1];
         m_div   = div_of(m_spd);
         m_upd   = m_gig || (m_p == (m_div + 1) / 2 - 1);
         m_acc   = s_axis_tvalid && e_tready;
         m_nst   = m_state;
         e_under = 1'b0;
         if (m_state == 3) begin
            if (m_upd) {e_txd1, e_txd2, e_c1, e_c2} = '0;
            m_ifg--;
            if (m_ifg == 0) m_nst = 0;
         end else if (m_upd) begin
            if (exp_q.size() == 0) begin
               if (m_acc && m_state != 2) begin
                  if (m_gig) begin
                     exp_q.push_back({s_axis_tlast, s_axis_tdata[3:0], s_axis_tdata[7:4], 1'b1, ~s_axis_tuser});
                  end else begin
                     exp_q.push_back({1'b0, s_axis_tdata[3:0], s_axis_tdata[3:0], 1'b1, ~s_axis_tuser});
                     exp_q.push_back({s_axis_tlast, s_axis_tdata[7:4], s_axis_tdata[7:4], 1'b1, ~s_axis_tuser});
                  end
                  m_nst = 1;
               end else if (m_state == 1) begin
                  exp_q.push_back(11'b0_0000_0000_10);
                  if (!m_gig) exp_q.push_back(11'b0_0000_0000_10);
                  e_under = 1'b1;
                  m_nst   = 2;
               end else if (m_state == 2 && m_acc) begin
                  exp_q.push_back(11'd0);
                  if (!m_gig) exp_q.push_back(11'd0);
                  if (s_axis_tlast) m_nst = 3;
               end
            end
            if (exp_q.size() != 0) begin
               m_ent = exp_q.pop_front();
               {e_txd1, e_txd2, e_c1, e_c2} = m_ent[9:0];
               if (m_ent[10]) m_nst = 3;
            end else begin
               {e_txd1, e_txd2, e_c1, e_c2} = '0;
            end
         end
         if (m_nst == 3 && m_state != 3) begin
            m_ifg = m_gig ? IFG_BYTES : IFG_BYTES * 2 * m_div;
            exp_q.delete();
         end
         if (m_state == 0 && m_nst == 0) m_spd = speed;
         m_state = m_nst;
         m_div   = div_of(m_spd);
         if (m_spd[1]) m_p = 0;
         else m_p = (m_p >= m_div - 1) ? 0 : m_p + 1;
         e_txc1   = m_spd[1] ? 1'b1 : (2 * m_p < m_div);
         e_txc2   = m_spd[1] ? 1'b0 : (2 * m_p + 1 < m_div);
         e_tready = (m_state != 3) && (m_spd[1] || (m_p == (m_div + 1) / 2 - 1 && exp_q.size() == 0));
         e_busy   = (m_state != 0);
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      chk("cyc_txd_d1", txd_d1, e_txd1);
      chk("cyc_txd_d2", txd_d2, e_txd2);
      chk("cyc_txctl_d1", txctl_d1, e_c1);
      chk("cyc_txctl_d2", txctl_d2, e_c2);
      chk("cyc_txc_d1", txc_d1, e_txc1);
      chk("cyc_txc_d2", txc_d2, e_txc2);
      chk("cyc_tready", s_axis_tready, e_tready);
      chk("cyc_busy", busy, e_busy);
      chk("cyc_underrun", status_underrun, e_under);
   end

   // ---------------- drivers ----------------
   // Called at a falling edge; returns at the falling edge right after acceptance.
   task automatic send_byte(input logic [7:0] d, input logic last, input logic user);
      int n;
      n = 0;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = d;
      s_axis_tlast  = last;
      s_axis_tuser  = user;
      while (!s_axis_tready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk("send_timeout", (n < 1000) ? 1 : 0, 1);
      @(negedge clk);
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      s_axis_tuser  = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while (busy && n < 5000) begin
         @(negedge clk);
         n++;
      end
      chk("wait_idle", busy, 0);
      repeat (3) @(negedge clk);
   endtask

   function automatic logic [9:0] line_now();
      return {txd_d1, txd_d2, txctl_d1, txctl_d2};
   endfunction

   logic [1:0] pat100[5];
   int hi_run, lo_run, n;

   initial begin
      speed = 2'b10; s_axis_tdata = 8'h00; s_axis_tvalid = 1'b0;
      s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_txc", {txc_d1, txc_d2}, 2'b00);
      chk("rst_tready", s_axis_tready, 0);
      chk("rst_line", line_now(), 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("g_idle_txc", {txc_d1, txc_d2}, 2'b10);
      chk("g_idle_tready", s_axis_tready, 1);

      // 1G four-byte frame
      send_byte(8'h11, 1'b0, 1'b0); chk("g4_b1", line_now(), {4'h1, 4'h1, 2'b11});
      send_byte(8'h22, 1'b0, 1'b0); chk("g4_b2", line_now(), {4'h2, 4'h2, 2'b11});
      send_byte(8'h33, 1'b0, 1'b0); chk("g4_b3", line_now(), {4'h3, 4'h3, 2'b11});
      send_byte(8'h44, 1'b1, 1'b0); chk("g4_b4", line_now(), {4'h4, 4'h4, 2'b11});
      for (int k = 0; k < 12; k++) begin
         chk("g4_gap_tready", s_axis_tready, 0);
         @(negedge clk);
      end
      chk("g4_idle_tready", s_axis_tready, 1);
      chk("g4_idle_line", line_now(), 0);
      wait_idle();

      // 1G error request
      send_byte(8'h3C, 1'b1, 1'b1); chk("g_tuser", line_now(), {4'hC, 4'h3, 2'b10});
      wait_idle();

      // 1G underrun after two bytes
      send_byte(8'h01, 1'b0, 1'b0);
      send_byte(8'h02, 1'b0, 1'b0);
      @(negedge clk);
      chk("ur_line", line_now(), {4'h0, 4'h0, 2'b10});
      chk("ur_pulse", status_underrun, 1);
      @(negedge clk);
      chk("ur_pulse_end", status_underrun, 0);
      send_byte(8'h03, 1'b0, 1'b0); chk("ur_discard1", line_now(), 0);
      send_byte(8'h04, 1'b1, 1'b0); chk("ur_discard2", line_now(), 0);
      chk("ur_gap_busy", busy, 1);
      wait_idle();

      // 100M single byte 0xA5
      speed = 2'b01;
      repeat (12) @(negedge clk);
      pat100 = '{2'b00, 2'b00, 2'b11, 2'b11, 2'b10};
      send_byte(8'hA5, 1'b1, 1'b0);
      for (int k = 0; k < 5; k++) begin
         chk("m100_lo", line_now(), {4'h5, 4'h5, 2'b11});
         chk("m100_txc", {txc_d1, txc_d2}, pat100[k]);
         @(negedge clk);
      end
      for (int k = 0; k < 5; k++) begin
         chk("m100_hi", line_now(), {4'hA, 4'hA, 2'b11});
         @(negedge clk);
      end
      chk("m100_after", line_now(), 0);
      wait_idle();

      // speed change 1G -> 10M inside a frame
      speed = 2'b10;
      repeat (4) @(negedge clk);
      send_byte(8'h10, 1'b0, 1'b0); chk("sc_b1", line_now(), {4'h0, 4'h1, 2'b11});
      speed = 2'b00;
      send_byte(8'h20, 1'b0, 1'b0); chk("sc_b2", line_now(), {4'h0, 4'h2, 2'b11});
      chk("sc_txc_still_1g", {txc_d1, txc_d2}, 2'b10);
      send_byte(8'h30, 1'b1, 1'b0); chk("sc_b3", line_now(), {4'h0, 4'h3, 2'b11});
      wait_idle();
      n = 0;
      while (txc_d1 && n < 300) begin @(negedge clk); n++; end
      while (!txc_d1 && n < 300) begin @(negedge clk); n++; end
      hi_run = 0;
      while (txc_d1 && hi_run < 300) begin hi_run++; @(negedge clk); end
      lo_run = 0;
      while (!txc_d1 && lo_run < 300) begin lo_run++; @(negedge clk); end
      chk("m10_txc_high", hi_run, 25);
      chk("m10_txc_low", lo_run, 25);

      // reset pulse during the third byte of a 10M frame
      send_byte(8'h11, 1'b0, 1'b0);
      send_byte(8'h22, 1'b0, 1'b0);
      send_byte(8'h33, 1'b0, 1'b0);
      chk("rs_b3_lo", line_now(), {4'h3, 4'h3, 2'b11});
      #1 rst = 1'b1;
      #1;
      chk("rs_line_zero", line_now(), 0);
      chk("rs_misc_zero", {txc_d1, txc_d2, s_axis_tready, busy, status_underrun}, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 200; k++) begin
         chk("rs_no_ctl", {txctl_d1, txctl_d2}, 0);
         @(negedge clk);
      end
      send_byte(8'h5A, 1'b1, 1'b0); chk("rs_new_frame", line_now(), {4'hA, 4'hA, 2'b11});
      wait_idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
      $fatal(1, "watchdog");
   end

endmodule
